// File: rtl/selector_row_streamer_if.sv
// Handshake bundle for selector_row_streamer.
// The master side is the streamer. The slave side is the testbench/host,
// which owns the control strobes, the ROM data and pix_ready.
interface selector_row_streamer_if #(
    parameter int AW   = 7,
    parameter int XW   = 6,
    parameter int COLS = 59
);
    // frame control
    logic            start;
    logic            abort;
    logic            busy;
    logic            frame_done;
    // shape ROM read port
    logic [AW-1:0]   rom_addr;
    logic [COLS-1:0] rom_data;
    // pixel stream
    logic            pix_valid;
    logic            pix_ready;
    logic            pix_data;
    logic [XW-1:0]   pix_x;
    logic [AW-1:0]   pix_y;
    logic            pix_eol;
    logic            pix_eof;

    modport master (
        input  start, abort, rom_data, pix_ready,
        output busy, frame_done, rom_addr,
               pix_valid, pix_data, pix_x, pix_y, pix_eol, pix_eof
    );

    modport slave (
        output start, abort, rom_data, pix_ready,
        input  busy, frame_done, rom_addr,
               pix_valid, pix_data, pix_x, pix_y, pix_eol, pix_eof
    );
endinterface

// File: rtl/selector_row_streamer.sv
// selector_row_streamer: walks the selector shape ROM row by row and
// serialises each row bitmap as a valid/ready pixel stream with row/column
// coordinates and end-of-line / end-of-frame markers.
// Optional build macro SELECTOR_MIRROR_EN: emit each row LSB first, which
// mirrors the shape horizontally. Coordinates and markers are unaffected.
module selector_row_streamer #(
    parameter int ROWS    = 66,
    parameter int COLS    = 59,
    parameter int AW      = 7,
    parameter int XW      = 6,
    parameter int ROM_LAT = 1
) (
    input  logic                    clk,
    input  logic                    rst,
    selector_row_streamer_if.master bus
);

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        LOAD,
        SHIFT,
        DONE
    } state_t;

    state_t          state;
    logic [1:0]      lat_cnt;
    logic [COLS-1:0] sreg;
    logic [COLS-1:0] sreg_next;
    logic [AW-1:0]   rom_addr;
    logic [AW-1:0]   pix_y;
    logic [XW-1:0]   pix_x;
    logic            pix_valid;
    logic            busy;
    logic            frame_done;
    logic            last_col;
    logic            last_row;

    // Column/row wrap is decided by explicit compares, never by counter overflow.
    assign last_col = (pix_x == XW'(COLS - 1));
    assign last_row = (pix_y == AW'(ROWS - 1));

`ifdef SELECTOR_MIRROR_EN
    // LSB first: pix_x = 0 carries rom_data[0].
    assign sreg_next    = sreg >> 1;
    assign bus.pix_data = sreg[0];
`else
    // MSB first: pix_x = 0 carries rom_data[COLS-1] (leftmost column).
    assign sreg_next    = sreg << 1;
    assign bus.pix_data = sreg[COLS-1];
`endif

    assign bus.rom_addr   = rom_addr;
    assign bus.pix_valid  = pix_valid;
    assign bus.pix_x      = pix_x;
    assign bus.pix_y      = pix_y;
    assign bus.busy       = busy;
    assign bus.frame_done = frame_done;
    assign bus.pix_eol    = pix_valid & last_col;
    assign bus.pix_eof    = pix_valid & last_col & last_row;

    // Frame sequencer: ROM fetch, row load, pixel shift-out and frame completion.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            lat_cnt    <= '0;
            sreg       <= '0;
            rom_addr   <= '0;
            pix_y      <= '0;
            pix_x      <= '0;
            pix_valid  <= 1'b0;
            busy       <= 1'b0;
            frame_done <= 1'b0;
        end else if (bus.abort) begin
            // Abort overrides every transition, including a coincident start.
            state      <= IDLE;
            lat_cnt    <= '0;
            sreg       <= '0;
            rom_addr   <= '0;
            pix_y      <= '0;
            pix_x      <= '0;
            pix_valid  <= 1'b0;
            busy       <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        rom_addr <= '0;
                        pix_y    <= '0;
                        pix_x    <= '0;
                        lat_cnt  <= '0;
                        busy     <= 1'b1;
                        state    <= FETCH;
                    end
                end
                FETCH: begin
                    // rom_addr is held stable while the ROM latency elapses.
                    if (lat_cnt == 2'(ROM_LAT - 1)) begin
                        lat_cnt <= '0;
                        state   <= LOAD;
                    end else begin
                        lat_cnt <= lat_cnt + 2'd1;
                    end
                end
                LOAD: begin
                    sreg      <= bus.rom_data;
                    pix_x     <= '0;
                    pix_valid <= 1'b1;
                    state     <= SHIFT;
                end
                SHIFT: begin
                    // pix_valid is always high here, so ready alone is the handshake.
                    if (bus.pix_ready) begin
                        sreg <= sreg_next;
                        if (last_col) begin
                            pix_x     <= '0;
                            pix_valid <= 1'b0;
                            if (last_row) begin
                                frame_done <= 1'b1;
                                state      <= DONE;
                            end else begin
                                pix_y    <= pix_y + AW'(1);
                                rom_addr <= rom_addr + AW'(1);
                                state    <= FETCH;
                            end
                        end else begin
                            pix_x <= pix_x + XW'(1);
                        end
                    end
                end
                DONE: begin
                    // start seen here is dropped; a new frame needs busy=0 first.
                    frame_done <= 1'b0;
                    busy       <= 1'b0;
                    state      <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_selector_row_streamer.sv
// Testbench for selector_row_streamer: ring-shaped ROM model, randomized
// pix_ready, and a coordinate/bitmap reference model built from the shape table.
module tb_selector_row_streamer;

    localparam int ROWS    = 66;
    localparam int COLS    = 59;
    localparam int AW      = 7;
    localparam int XW      = 6;
    localparam int ROM_LAT = 1;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    selector_row_streamer_if #(.AW(AW), .XW(XW), .COLS(COLS)) bus ();

    selector_row_streamer #(
        .ROWS(ROWS), .COLS(COLS), .AW(AW), .XW(XW), .ROM_LAT(ROM_LAT)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // shape table: on_col[r][c] = column c of row r is lit (column 0 = leftmost)
    bit              on_col  [ROWS][COLS];
    logic [COLS-1:0] rom_word [0:(1<<AW)-1];
    logic [COLS-1:0] rom_pipe [ROM_LAT];

    always @(posedge clk) begin
        rom_pipe[0] <= rom_word[bus.rom_addr];
        for (int i = 1; i < ROM_LAT; i++) rom_pipe[i] <= rom_pipe[i-1];
    end
    assign bus.rom_data = rom_pipe[ROM_LAT-1];

    // scoreboard state
    int n_cmp, n_fail;
    int cyc;
    int hs_cnt, order_err, pix_err, eol_err, eof_err, stab_err, gap_err;
    int fd_cnt, fd_cyc, eof_cyc, first_vld_cyc, gap17, gap_run;
    int exp_x, exp_y;
    bit in_gap, prev_stall, start_on_done;
    logic [XW+AW+3:0] prev_vals;
    bit cap [ROWS][COLS];

    function automatic bit model_pix(int x, int y);
`ifdef SELECTOR_MIRROR_EN
        return on_col[y][COLS-1-x];
`else
        return on_col[y][x];
`endif
    endfunction

    task automatic build_rom();
        for (int i = 0; i < (1 << AW); i++) rom_word[i] = '0;
        for (int r = 0; r < ROWS; r++) begin
            for (int c = 0; c < COLS; c++) begin
                bit v;
                v = 1'b0;
                if ((r == 0 || r == ROWS-1) && c >= 26 && c <= 32) v = 1'b1;
                if (r >= 17 && r <= 48 && (c == 0 || c == 1 || c == 57 || c == 58)) v = 1'b1;
                if (r == 5 && ((c >= 3 && c <= 10) || c == 50)) v = 1'b1;
                if (r >= 60 && r <= 63) v = 1'($urandom_range(1));
                on_col[r][c] = v;
                rom_word[r][COLS-1-c] = v;
            end
        end
    endtask

    task automatic clear_stats();
        hs_cnt = 0; order_err = 0; pix_err = 0; eol_err = 0; eof_err = 0;
        stab_err = 0; gap_err = 0; fd_cnt = 0; fd_cyc = -1; eof_cyc = -1;
        first_vld_cyc = -1; gap17 = -1; gap_run = 0;
        exp_x = 0; exp_y = 0; in_gap = 0; prev_stall = 0; start_on_done = 0;
        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++) cap[r][c] = 1'b0;
    endtask

    // One clock: drive inputs at the falling edge and record what the stream shows.
    task automatic cycle(input bit rdy, input bit st, input bit ab);
        int x, y;
        logic [XW+AW+3:0] cur;
        @(negedge clk);
        cyc++;
        bus.pix_ready = rdy;
        bus.start     = st | (start_on_done & bus.frame_done);
        bus.abort     = ab;
        x = int'(bus.pix_x);
        y = int'(bus.pix_y);
        cur = {bus.pix_valid, bus.pix_data, bus.pix_x, bus.pix_y, bus.pix_eol, bus.pix_eof};
        if (bus.frame_done) begin fd_cnt++; fd_cyc = cyc; end
        if (prev_stall && cur !== prev_vals) stab_err++;
        prev_stall = bus.pix_valid & ~rdy;
        prev_vals  = cur;
        if (bus.pix_valid) begin
            if (bus.pix_eol !== (x == COLS-1)) eol_err++;
            if (bus.pix_eof !== (x == COLS-1 && y == ROWS-1)) eof_err++;
            if (first_vld_cyc < 0) first_vld_cyc = cyc;
            if (in_gap) begin
                if (gap_run != ROM_LAT + 1) gap_err++;
                if (y == 18) gap17 = gap_run;
                in_gap = 0;
            end
        end else if (in_gap) begin
            gap_run++;
        end
        if (bus.pix_valid && rdy && !ab) begin
            hs_cnt++;
            if (x != exp_x || y != exp_y) order_err++;
            if (x < COLS && y < ROWS) begin
                cap[y][x] = bus.pix_data;
                if (bus.pix_data !== model_pix(x, y)) pix_err++;
            end else begin
                order_err++;
            end
            if (exp_x == COLS-1) begin
                if (exp_y == ROWS-1) begin eof_cyc = cyc; exp_y = 0; end
                else begin in_gap = 1; gap_run = 0; exp_y++; end
                exp_x = 0;
            end else begin
                exp_x++;
            end
        end
    endtask

    task automatic run_frame(input int budget, input int ready_pct);
        for (int i = 0; i < budget && fd_cnt == 0; i++)
            cycle(($urandom_range(99) < ready_pct), 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0, 1'b0);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        cycle(1'b0, 1'b0, 1'b0);
        n_cmp++;
        if ({bus.pix_valid, bus.busy, bus.frame_done, bus.pix_eol, bus.pix_eof, bus.pix_data} !== 6'b0) begin
            n_fail++; $display("FAIL reset_flags: got %b expected 000000",
                {bus.pix_valid, bus.busy, bus.frame_done, bus.pix_eol, bus.pix_eof, bus.pix_data});
        end
        n_cmp++;
        if (bus.rom_addr !== '0) begin n_fail++; $display("FAIL reset_rom_addr: got %0d expected 0", bus.rom_addr); end
        n_cmp++;
        if ({bus.pix_x, bus.pix_y} !== '0) begin
            n_fail++; $display("FAIL reset_xy: got x=%0d y=%0d expected 0,0", bus.pix_x, bus.pix_y);
        end
        rst = 1'b0;
        for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0, 1'b0);
        n_cmp++;
        if ({bus.busy, bus.pix_valid} !== 2'b00) begin
            n_fail++; $display("FAIL idle_after_reset: got busy/valid=%b expected 00", {bus.busy, bus.pix_valid});
        end
    endtask

    task automatic test_full_frame();
        int start_cyc, row0_bad;
        clear_stats();
        cycle(1'b1, 1'b1, 1'b0);
        start_cyc = cyc;
        cycle(1'b1, 1'b0, 1'b0);
        n_cmp++;
        if (bus.busy !== 1'b1) begin n_fail++; $display("FAIL busy_after_start: got %b expected 1", bus.busy); end
        run_frame(6000, 100);
        n_cmp++;
        if (hs_cnt !== ROWS*COLS) begin n_fail++; $display("FAIL full_handshakes: got %0d expected %0d", hs_cnt, ROWS*COLS); end
        n_cmp++;
        if (first_vld_cyc - start_cyc !== ROM_LAT + 2) begin
            n_fail++; $display("FAIL first_pixel_latency: got %0d expected %0d", first_vld_cyc - start_cyc, ROM_LAT + 2);
        end
        n_cmp++;
        if ({order_err, pix_err} !== 64'd0) begin
            n_fail++; $display("FAIL full_order_data: got order_err=%0d pix_err=%0d expected 0,0", order_err, pix_err);
        end
        n_cmp++;
        if ({eol_err, eof_err} !== 64'd0) begin
            n_fail++; $display("FAIL full_markers: got eol_err=%0d eof_err=%0d expected 0,0", eol_err, eof_err);
        end
        row0_bad = 0;
        for (int x = 0; x < COLS; x++) if (cap[0][x] != (x >= 26 && x <= 32)) row0_bad++;
        n_cmp++;
        if (row0_bad !== 0) begin n_fail++; $display("FAIL row0_pattern: got %0d wrong pixels expected 0", row0_bad); end
        n_cmp++;
`ifdef SELECTOR_MIRROR_EN
        if ({cap[5][3], cap[5][55]} !== 2'b01) begin
            n_fail++; $display("FAIL row5_orientation: got %b expected 01", {cap[5][3], cap[5][55]});
        end
`else
        if ({cap[5][3], cap[5][55]} !== 2'b10) begin
            n_fail++; $display("FAIL row5_orientation: got %b expected 10", {cap[5][3], cap[5][55]});
        end
`endif
        n_cmp++;
        if (fd_cnt !== 1) begin n_fail++; $display("FAIL full_frame_done_count: got %0d expected 1", fd_cnt); end
        n_cmp++;
        if (fd_cyc !== eof_cyc + 1) begin
            n_fail++; $display("FAIL frame_done_timing: got cycle %0d expected %0d", fd_cyc, eof_cyc + 1);
        end
        n_cmp++;
        if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL busy_after_frame: got %b expected 0", bus.busy); end
    endtask

    task automatic test_row_gap();
        int row17_bad;
        clear_stats();
        cycle(1'b1, 1'b1, 1'b0);
        run_frame(6000, 100);
        n_cmp++;
        if (gap17 !== ROM_LAT + 1) begin n_fail++; $display("FAIL row17_gap: got %0d expected %0d", gap17, ROM_LAT + 1); end
        n_cmp++;
        if (gap_err !== 0) begin n_fail++; $display("FAIL row_gaps: got %0d bad gaps expected 0", gap_err); end
        row17_bad = 0;
        for (int x = 0; x < COLS; x++)
            if (cap[17][x] != (x == 0 || x == 1 || x == 57 || x == 58)) row17_bad++;
        n_cmp++;
        if (row17_bad !== 0) begin n_fail++; $display("FAIL row17_pattern: got %0d wrong pixels expected 0", row17_bad); end
        n_cmp++;
        if (eol_err !== 0) begin n_fail++; $display("FAIL row_gap_eol: got %0d expected 0", eol_err); end
    endtask

    task automatic test_random_ready();
        int bad;
        clear_stats();
        cycle(1'b1, 1'b1, 1'b0);
        run_frame(20000, 50);
        n_cmp++;
        if (hs_cnt !== ROWS*COLS) begin n_fail++; $display("FAIL rand_handshakes: got %0d expected %0d", hs_cnt, ROWS*COLS); end
        bad = 0;
        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++) if (cap[r][c] != model_pix(c, r)) bad++;
        n_cmp++;
        if (bad !== 0) begin n_fail++; $display("FAIL rand_bitmap: got %0d wrong pixels expected 0", bad); end
        n_cmp++;
        if (stab_err !== 0) begin n_fail++; $display("FAIL rand_stall_stable: got %0d changes expected 0", stab_err); end
        n_cmp++;
        if ({order_err, fd_cnt} !== {32'd0, 32'd1}) begin
            n_fail++; $display("FAIL rand_order_done: got order_err=%0d frame_done=%0d expected 0,1", order_err, fd_cnt);
        end
    endtask

    task automatic test_abort();
        bit found;
        clear_stats();
        found = 0;
        cycle(1'b1, 1'b1, 1'b0);
        for (int i = 0; i < 4000 && !found; i++) begin
            cycle(1'b1, 1'b0, 1'b0);
            if (bus.pix_valid && bus.pix_y == AW'(30) && bus.pix_x == XW'(9)) found = 1;
        end
        cycle(1'b0, 1'b0, 1'b1);
        n_cmp++;
        if ({bus.pix_valid, bus.pix_y, bus.pix_x} !== {1'b1, AW'(30), XW'(10)}) begin
            n_fail++; $display("FAIL abort_point: got valid=%b y=%0d x=%0d expected 1,30,10",
                bus.pix_valid, bus.pix_y, bus.pix_x);
        end
        cycle(1'b1, 1'b0, 1'b0);
        n_cmp++;
        if ({bus.busy, bus.pix_valid, bus.frame_done} !== 3'b000) begin
            n_fail++; $display("FAIL abort_flags: got busy/valid/done=%b expected 000",
                {bus.busy, bus.pix_valid, bus.frame_done});
        end
        n_cmp++;
        if ({bus.pix_x, bus.pix_y, bus.rom_addr} !== '0) begin
            n_fail++; $display("FAIL abort_counters: got x=%0d y=%0d addr=%0d expected 0,0,0",
                bus.pix_x, bus.pix_y, bus.rom_addr);
        end
        for (int i = 0; i < 10; i++) cycle(1'b1, 1'b0, 1'b0);
        n_cmp++;
        if (fd_cnt !== 0) begin n_fail++; $display("FAIL abort_no_done: got %0d expected 0", fd_cnt); end
        clear_stats();
        cycle(1'b1, 1'b1, 1'b0);
        run_frame(6000, 100);
        n_cmp++;
        if ({hs_cnt, order_err} !== {32'(ROWS*COLS), 32'd0}) begin
            n_fail++; $display("FAIL restart_after_abort: got hs=%0d order_err=%0d expected %0d,0",
                hs_cnt, order_err, ROWS*COLS);
        end
    endtask

    task automatic test_start_ignored();
        clear_stats();
        cycle(1'b1, 1'b1, 1'b0);
        for (int i = 0; i < 200; i++) cycle(1'b1, (i == 100), 1'b0);
        start_on_done = 1;
        run_frame(6000, 100);
        start_on_done = 0;
        for (int i = 0; i < 5; i++) cycle(1'b1, 1'b0, 1'b0);
        n_cmp++;
        if (fd_cnt !== 1) begin n_fail++; $display("FAIL ignored_start_done_count: got %0d expected 1", fd_cnt); end
        n_cmp++;
        if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL start_in_done_ignored: got busy=%b expected 0", bus.busy); end
        n_cmp++;
        if ({hs_cnt, order_err} !== {32'(ROWS*COLS), 32'd0}) begin
            n_fail++; $display("FAIL start_while_busy_ignored: got hs=%0d order_err=%0d expected %0d,0",
                hs_cnt, order_err, ROWS*COLS);
        end
        cycle(1'b1, 1'b1, 1'b0);
        cycle(1'b1, 1'b0, 1'b0);
        n_cmp++;
        if (bus.busy !== 1'b1) begin n_fail++; $display("FAIL start_after_idle: got busy=%b expected 1", bus.busy); end
        cycle(1'b1, 1'b0, 1'b1);
        cycle(1'b1, 1'b0, 1'b0);
    endtask

    task automatic test_async_rst();
        bit found;
        clear_stats();
        found = 0;
        cycle(1'b1, 1'b1, 1'b0);
        for (int i = 0; i < 1000 && !found; i++) begin
            cycle(1'b1, 1'b0, 1'b0);
            if (bus.pix_valid && bus.pix_y == AW'(2) && bus.pix_x == XW'(20)) found = 1;
        end
        #2 rst = 1'b1;
        #1;
        n_cmp++;
        if ({bus.pix_valid, bus.busy, bus.frame_done, bus.pix_eol, bus.pix_eof, bus.pix_data,
             bus.pix_x, bus.pix_y, bus.rom_addr} !== '0) begin
            n_fail++; $display("FAIL async_rst_outputs: got valid=%b busy=%b x=%0d y=%0d addr=%0d expected all 0",
                bus.pix_valid, bus.busy, bus.pix_x, bus.pix_y, bus.rom_addr);
        end
        cycle(1'b1, 1'b0, 1'b0);
        rst = 1'b0;
        for (int i = 0; i < 5; i++) cycle(1'b1, 1'b0, 1'b0);
        n_cmp++;
        if ({bus.busy, bus.pix_valid, 32'(fd_cnt)} !== 34'd0) begin
            n_fail++; $display("FAIL async_rst_idle: got busy=%b valid=%b done=%0d expected 0,0,0",
                bus.busy, bus.pix_valid, fd_cnt);
        end
    endtask

    initial begin
        n_cmp = 0; n_fail = 0; cyc = 0;
        bus.start = 1'b0; bus.abort = 1'b0; bus.pix_ready = 1'b0;
        rst = 1'b1;
        build_rom();
        clear_stats();
        test_reset();
        test_full_frame();
        test_row_gap();
        test_random_ready();
        test_abort();
        test_start_ignored();
        test_async_rst();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
